branch_pc_ctrl: RTL

Static branch prediction and PC-select controller for the 5-stage pipeline. It decodes B-type instructions in Fetch and predicts backward branches taken and forward branches not taken (BTFN). It tracks each prediction through Decode and Execute, and on a misprediction it issues flushes and a recovery PC. Its `pc_sel`/`pc_redirect`/`pred_target` outputs drive the two cascaded 32-bit 2:1 muxes in front of the PC register.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/br_track_reg.sv | 20 ++
 rtl/branch_pc_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/bp_pkg.sv
// Shared types for the static branch predictor: opcode, PC-select encoding,
// per-stage tracking entry and B-type immediate decode.
package bp_pkg;

  localparam int          PC_W      = 32;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'b00,
    PC_PRED  = 2'b01,
    PC_REDIR = 2'b10
  } pc_sel_e;

  // alt_pc is the path the prediction did not choose, i.e. the recovery PC
  typedef struct packed {
    logic            valid;
    logic            is_br;
    logic            pred_taken;
    logic [PC_W-1:0] alt_pc;
  } br_track_t;

  function automatic logic [PC_W-1:0] bimm(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/br_track_reg.sv
// One pipeline stage of branch tracking state; clr beats en so a flush
// always empties the stage even when it is stalled.
module br_track_reg
  import bp_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  logic      clr,
  input  br_track_t d,
  output br_track_t q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/branch_pc_ctrl.sv
// BTFN static predictor and PC-select controller: predicts in Fetch, tracks
// the prediction through ID/EX, and redirects/flushes on a mispredict in EX.
module branch_pc_ctrl
  import bp_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pred_en,
  input  logic [XLEN-1:0]  instr_f,
  input  logic [XLEN-1:0]  pc_f,
  input  logic             stall_d,
  input  logic             flush_e_ext,
  input  logic             taken_e,
  output logic [1:0]       pc_sel,
  output logic [XLEN-1:0]  pred_target,
  output logic [XLEN-1:0]  pc_redirect,
  output logic             flush_d,
  output logic             flush_e,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic            is_br_f, pred_taken_f, br_e, mis_e;
  logic [XLEN-1:0] pc_plus4;
  br_track_t       ent_f, ent_d, ent_e;
  pc_sel_e         sel;

  assign is_br_f      = (instr_f[6:0] == OP_BRANCH);
  // Backward branches have a negative immediate, so the sign bit is the hint
  assign pred_taken_f = is_br_f & pred_en & instr_f[31];
  assign pc_plus4     = pc_f + XLEN'(4);
  assign pred_target  = pc_f + bimm(instr_f);

  always_comb begin
    ent_f            = '0;
    ent_f.valid      = 1'b1;
    ent_f.is_br      = is_br_f;
    ent_f.pred_taken = pred_taken_f;
    ent_f.alt_pc     = pred_taken_f ? pc_plus4 : pred_target;
  end

  br_track_reg u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!stall_d),
    .clr   (flush_d),
    .d     (ent_f),
    .q     (ent_d)
  );

  // A stalled decode stage must not advance into EX, so stall also bubbles EX
  br_track_reg u_idex (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .clr   (flush_e | flush_e_ext | stall_d),
    .d     (ent_d),
    .q     (ent_e)
  );

  assign br_e  = ent_e.valid & ent_e.is_br;
  assign mis_e = br_e & (taken_e != ent_e.pred_taken);

  always_comb begin
    sel = PC_SEQ;
    if (!rst_n)            sel = PC_SEQ;
    else if (mis_e)        sel = PC_REDIR;
    else if (pred_taken_f) sel = PC_PRED;
  end

  assign pc_sel      = sel;
  assign pc_redirect = ent_e.alt_pc;
  assign flush_d     = mis_e;
  assign flush_e     = mis_e;
  assign mispredict  = mis_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (br_e  && br_cnt      != '1) br_cnt      <= br_cnt + 1'b1;
      if (mis_e && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 1'b1;
    end
  end

endmodule
